gen_waddr_mb: RTL and testbench
===============================

Name: gen_waddr_mb

Overview:
Parametrised successor of the line-buffer write-address generator. Generates bank-select and in-bank SRAM write addresses for N line-buffer banks. Counts lines internally instead of relying on an external 2-line strobe, and tracks bank occupancy against reader releases so it can stall the writer. Sits between the input pixel stream and the bank SRAMs, upstream of the window/read-address logic.

Parameters:
AW, 10, in-bank address width
NBANK, 3, number of line-buffer banks (2..4)
BW, 2, bank-select width, equals clog2(NBANK), minimum 1
LPB, 2, lines per bank in conv mode (1..255)

Ports:
SYS_CLK  in  1  clock
SYS_RST  in  1  asynchronous active-low reset
DATA_SOP  in  1  one-cycle frame-start pulse, precedes first beat
DATA_VLD  in  1  input beat valid
DATA_EOL  in  1  last beat of line, qualified by accepted beat
WREADY  in  1  SRAM can accept write
BANK_RELEASE  in  1  one-cycle pulse: reader freed oldest bank
WRADDR_START  in  AW  in-bank start address
PIC_SIZE  in  8  lines per frame (0 = unlimited)
PADDING  in  1  apply padding offset at SOP
MODE  in  4  MODE[3]=1 fully-connected, 0 conv; [2:0] reserved
WADDR  out  AW+BW  {bank, in-bank addr}
WEN  out  1  write strobe for current WADDR
BANK_FULL  out  1  all banks occupied, writer stalled
BANK_DONE  out  1  one-cycle pulse: a bank completed
BANK_DONE_ID  out  BW  index of completed bank
FRAME_DONE  out  1  one-cycle pulse: last line of frame written

Behaviour:
- Reset (async, SYS_RST=0): state IDLE; WADDR=0, WEN=0, BANK_FULL=0, BANK_DONE=0, BANK_DONE_ID=0, FRAME_DONE=0; line, frame-line and occupancy counters 0.
- States: IDLE, WRITE, STALL. IDLE->WRITE on DATA_SOP. WRITE->STALL when occupancy reaches NBANK. STALL->WRITE on BANK_RELEASE. WRITE->IDLE on FRAME_DONE. DATA_SOP from any state -> WRITE.
- WEN is combinational: DATA_VLD & WREADY & (state==WRITE). Beats are ignored in IDLE and STALL.
- Accepted beat (WEN=1): in-bank address +1 on the next cycle, modulo 2^AW.
- DATA_SOP has highest priority. It sets bank=0, line counters=0 and occupancy=0, and sets the in-bank address to (WRADDR_START + (PADDING ? PIC_SIZE*8 : 0)) mod 2^AW. The sum is computed in 11 bits and then truncated to AW. A beat coincident with SOP is dropped.
- Conv mode (MODE[3]=0):
  - An accepted beat with DATA_EOL increments the line counter.
  - On the LPB-th EOL the bank completes. Next cycle: BANK_DONE=1, BANK_DONE_ID=old bank, bank=(bank==NBANK-1)?0:bank+1, in-bank address=WRADDR_START, line counter=0, occupancy+1.
- FC mode (MODE[3]=1):
  - DATA_EOL ignored for banking.
  - The bank completes when a beat is accepted at in-bank address 2^AW-1. The address wraps to 0 and the bank advances as above.
- Frame end (conv only, PIC_SIZE!=0): the frame-line counter counts EOLs. On the EOL that makes it equal PIC_SIZE, FRAME_DONE pulses next cycle and state goes to IDLE. A partially filled bank is then reported with BANK_DONE in that same cycle.
- Occupancy (0..NBANK):
  - Bank completion and release in the same cycle: no change.
  - Release at 0: ignored.
  - BANK_FULL = (occupancy==NBANK), registered with the state.
- MODE, PIC_SIZE, PADDING and WRADDR_START are sampled freely; they must be held stable from SOP to FRAME_DONE.
- Reset mid-frame aborts everything immediately. No pulses are emitted.

Decomposition:
- Shared package gen_waddr_pkg: state enum (IDLE/WRITE/STALL), MODE bit index constant MODE_FC=3, padding shift constant PAD_SHIFT=3.
- One sub-module, bank_occ_cnt: occupancy up/down counter with saturation and full flag, parametrised by NBANK.

Test Plan:
1. AW=10, START=0x010, PADDING=1, PIC_SIZE=4, SOP -> next cycle WADDR={0,0x030}. Same with PADDING=0 -> {0,0x010}.
2. Conv, LPB=2, lines of 5 beats, START=0 -> beats at 0..9 in bank0. After the 2nd EOL: BANK_DONE=1, ID=0, WADDR={1,0x000}.
3. NBANK=3, 6 lines, no release -> BANK_FULL=1 after bank2 completes, WEN=0 while VLD&WREADY=1. One BANK_RELEASE -> WRITE next cycle, WADDR={0,START}, WEN resumes.
4. Occupancy 2, bank completion and BANK_RELEASE in the same cycle -> occupancy stays 2, BANK_FULL stays 0.
5. FC mode, AW=4, 16 beats from 0 -> BANK_DONE after the beat at 0xF, WADDR={1,0x0}. EOL pulses cause no bank change.
6. PIC_SIZE=3, LPB=2 -> FRAME_DONE and BANK_DONE(ID=1) after the 3rd EOL, state IDLE, further beats WEN=0. Reset asserted mid-line -> all outputs 0 immediately.

Source files
------------

// File: rtl/gen_waddr_pkg.sv
// Shared types and constants for the multi-bank line-buffer write-address generator.
package gen_waddr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  localparam int unsigned MODE_FC   = 3;
  localparam int unsigned PAD_SHIFT = 3;
  localparam int unsigned SOP_SUM_W = 11;
  localparam int unsigned PIC_W     = 8;

endpackage

// File: rtl/bank_occ_cnt.sv
// Bank occupancy counter: counts completed banks not yet released by the reader,
// saturating at NBANK, with a registered full flag and its next-cycle value.
module bank_occ_cnt #(
  parameter int unsigned NBANK = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_full_nxt_c
);

  localparam int unsigned CW = $clog2(NBANK + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_full;

  // Simultaneous completion and release cancel; release at zero is ignored.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_inc && !i_dec) begin
      if (r_cnt != CW'(NBANK)) w_cnt_nxt = r_cnt + CW'(1);
    end else if (i_dec && !i_inc) begin
      if (r_cnt != '0) w_cnt_nxt = r_cnt - CW'(1);
    end
  end

  assign o_full_nxt_c = (w_cnt_nxt == CW'(NBANK));
  assign o_full       = r_full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_full <= o_full_nxt_c;
    end
  end

endmodule

// File: rtl/gen_waddr_mb.sv
// Multi-bank line-buffer write-address generator: counts lines per bank (conv)
// or address wraps (FC), rotates banks and stalls the writer when all are occupied.
module gen_waddr_mb
  import gen_waddr_pkg::*;
#(
  parameter int unsigned AW    = 10,
  parameter int unsigned NBANK = 3,
  parameter int unsigned BW    = 2,
  parameter int unsigned LPB   = 2
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RST,
  input  logic              DATA_SOP,
  input  logic              DATA_VLD,
  input  logic              DATA_EOL,
  input  logic              WREADY,
  input  logic              BANK_RELEASE,
  input  logic [AW-1:0]     WRADDR_START,
  input  logic [PIC_W-1:0]  PIC_SIZE,
  input  logic              PADDING,
  input  logic [3:0]        MODE,
  output logic [AW+BW-1:0]  WADDR,
  output logic              WEN,
  output logic              BANK_FULL,
  output logic              BANK_DONE,
  output logic [BW-1:0]     BANK_DONE_ID,
  output logic              FRAME_DONE
);

  state_e                 r_state, w_state_nxt;
  logic [BW-1:0]          r_bank, w_bank_nxt, w_bank_inc;
  logic [BW-1:0]          r_done_id, w_done_id_nxt;
  logic [AW-1:0]          r_addr, w_addr_nxt, w_sop_addr;
  logic [PIC_W-1:0]       r_line, w_line_nxt, r_fline, w_fline_nxt;
  logic                   r_bank_done, w_bank_done_nxt;
  logic                   r_frame_done, w_frame_done_nxt;
  logic [SOP_SUM_W-1:0]   w_sop_sum;
  logic                   w_acc, w_eol_acc, w_fc;
  logic                   w_line_last, w_frame_end, w_fc_wrap, w_bank_cmp;
  logic                   w_full, w_full_nxt;
  logic                   w_unused_mode;

  assign w_unused_mode = ^MODE[2:0];
  assign w_fc          = MODE[MODE_FC];

  // A beat coincident with SOP is dropped, so SOP masks the strobe.
  assign w_acc     = DATA_VLD & WREADY & (r_state == ST_WRITE) & ~DATA_SOP;
  assign w_eol_acc = w_acc & DATA_EOL;
  assign WEN       = w_acc;

  assign w_sop_sum  = SOP_SUM_W'(WRADDR_START)
                    + (PADDING ? (SOP_SUM_W'(PIC_SIZE) << PAD_SHIFT) : SOP_SUM_W'(0));
  assign w_sop_addr = AW'(w_sop_sum);

  assign w_line_last = w_eol_acc & ~w_fc & (r_line == PIC_W'(LPB - 1));
  assign w_frame_end = w_eol_acc & ~w_fc & (PIC_SIZE != '0) & (r_fline == PIC_SIZE - PIC_W'(1));
  assign w_fc_wrap   = w_acc & w_fc & (&r_addr);
  // Frame end closes a partially filled bank as well.
  assign w_bank_cmp  = w_line_last | w_frame_end | w_fc_wrap;
  assign w_bank_inc  = (r_bank == BW'(NBANK - 1)) ? '0 : r_bank + BW'(1);

  bank_occ_cnt #(
    .NBANK (NBANK)
  ) u_occ (
    .i_clk        (SYS_CLK),
    .i_rst_n      (SYS_RST),
    .i_clr        (DATA_SOP),
    .i_inc        (w_bank_cmp),
    .i_dec        (BANK_RELEASE),
    .o_full       (w_full),
    .o_full_nxt_c (w_full_nxt)
  );

  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (DATA_SOP) begin
      w_state_nxt = ST_WRITE;
    end else begin
      unique case (r_state)
        ST_IDLE:  w_state_nxt = ST_IDLE;
        ST_WRITE: begin
          if (w_frame_end)     w_state_nxt = ST_IDLE;
          else if (w_full_nxt) w_state_nxt = ST_STALL;
        end
        ST_STALL: if (BANK_RELEASE) w_state_nxt = ST_WRITE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Address, bank, line counters and completion pulses for the next cycle.
  always_comb begin
    w_addr_nxt       = r_addr;
    w_bank_nxt       = r_bank;
    w_line_nxt       = r_line;
    w_fline_nxt      = r_fline;
    w_done_id_nxt    = r_done_id;
    w_bank_done_nxt  = 1'b0;
    w_frame_done_nxt = 1'b0;
    if (DATA_SOP) begin
      w_addr_nxt  = w_sop_addr;
      w_bank_nxt  = '0;
      w_line_nxt  = '0;
      w_fline_nxt = '0;
    end else if (w_acc) begin
      w_addr_nxt = r_addr + AW'(1);
      if (w_eol_acc && !w_fc) begin
        w_line_nxt  = r_line + PIC_W'(1);
        w_fline_nxt = r_fline + PIC_W'(1);
      end
      if (w_bank_cmp) begin
        w_bank_done_nxt = 1'b1;
        w_done_id_nxt   = r_bank;
        w_bank_nxt      = w_bank_inc;
        w_line_nxt      = '0;
        if (!w_fc) w_addr_nxt = WRADDR_START;
      end
      if (w_frame_end) begin
        w_frame_done_nxt = 1'b1;
        w_fline_nxt      = '0;
      end
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      r_addr       <= '0;
      r_bank       <= '0;
      r_line       <= '0;
      r_fline      <= '0;
      r_done_id    <= '0;
      r_bank_done  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_addr       <= w_addr_nxt;
      r_bank       <= w_bank_nxt;
      r_line       <= w_line_nxt;
      r_fline      <= w_fline_nxt;
      r_done_id    <= w_done_id_nxt;
      r_bank_done  <= w_bank_done_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign WADDR        = {r_bank, r_addr};
  assign BANK_FULL    = w_full;
  assign BANK_DONE    = r_bank_done;
  assign BANK_DONE_ID = r_done_id;
  assign FRAME_DONE   = r_frame_done;

endmodule

// File: tb/tb_gen_waddr_mb.sv
// Scoreboard bench for gen_waddr_mb: a transaction-level model queues expected
// writes, bank/frame completions and full status; a negedge monitor checks them.
module tb_gen_waddr_mb;

  localparam int AW    = 10;
  localparam int NBANK = 3;
  localparam int BW    = 2;
  localparam int LPB   = 2;
  localparam int SPAN  = 1 << AW;

  logic          SYS_CLK = 1'b0;
  logic          SYS_RST = 1'b1;
  logic          DATA_SOP = 1'b0, DATA_VLD = 1'b0, DATA_EOL = 1'b0;
  logic          WREADY = 1'b0, BANK_RELEASE = 1'b0;
  logic [AW-1:0] WRADDR_START;
  logic [7:0]    PIC_SIZE;
  logic          PADDING;
  logic [3:0]    MODE;
  logic [AW+BW-1:0] WADDR;
  logic          WEN, BANK_FULL, BANK_DONE, FRAME_DONE;
  logic [BW-1:0] BANK_DONE_ID;

  int cfg_start = 0, cfg_pic = 0;
  bit cfg_pad = 1'b0, cfg_fc = 1'b0;

  assign WRADDR_START = AW'(cfg_start);
  assign PIC_SIZE     = 8'(cfg_pic);
  assign PADDING      = cfg_pad;
  assign MODE         = {cfg_fc, 3'b000};

  gen_waddr_mb #(.AW(AW), .NBANK(NBANK), .BW(BW), .LPB(LPB)) dut (
    .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .DATA_SOP(DATA_SOP), .DATA_VLD(DATA_VLD),
    .DATA_EOL(DATA_EOL), .WREADY(WREADY), .BANK_RELEASE(BANK_RELEASE),
    .WRADDR_START(WRADDR_START), .PIC_SIZE(PIC_SIZE), .PADDING(PADDING), .MODE(MODE),
    .WADDR(WADDR), .WEN(WEN), .BANK_FULL(BANK_FULL), .BANK_DONE(BANK_DONE),
    .BANK_DONE_ID(BANK_DONE_ID), .FRAME_DONE(FRAME_DONE)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int n_tests = 0, n_fail = 0;
  bit mon_en = 1'b0;

  int addr_q[$];
  int done_q[$];
  int frame_q[$];
  bit full_q[$];

  // Reference model state: plain integers following the behavioural rules.
  bit m_active;
  int m_bank, m_addr, m_line, m_fline, m_occ;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: actual 0x%0h with no expected entry at %0t", name, act, $time);
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_bank = 0; m_addr = 0; m_line = 0; m_fline = 0; m_occ = 0;
  endtask

  task automatic model_step(input bit sop, input bit vld, input bit eol,
                            input bit wr, input bit rel);
    bit acc, done, frame;
    int old;
    full_q.push_back(m_occ == NBANK);
    if (sop) begin
      m_active = 1'b1; m_bank = 0; m_line = 0; m_fline = 0; m_occ = 0;
      m_addr = ((cfg_start + (cfg_pad ? cfg_pic * 8 : 0)) % 2048) % SPAN;
      return;
    end
    acc = m_active && (m_occ < NBANK) && vld && wr;
    done = 1'b0;
    frame = 1'b0;
    if (acc) begin
      addr_q.push_back(m_bank * SPAN + m_addr);
      old = m_addr;
      m_addr = (m_addr + 1) % SPAN;
      if (cfg_fc) begin
        done = (old == SPAN - 1);
      end else if (eol) begin
        m_line++;
        m_fline++;
        if (m_line == LPB) done = 1'b1;
        if (cfg_pic != 0 && m_fline == cfg_pic) begin
          frame = 1'b1;
          done = 1'b1;
        end
      end
      if (done) begin
        done_q.push_back(m_bank);
        m_bank = (m_bank + 1) % NBANK;
        m_line = 0;
        if (!cfg_fc) m_addr = cfg_start;
      end
      if (frame) begin
        frame_q.push_back(1);
        m_active = 1'b0;
        m_fline = 0;
      end
    end
    if (done && !rel && m_occ < NBANK) m_occ++;
    else if (rel && !done && m_occ > 0) m_occ--;
  endtask

  task automatic drive(input bit sop, input bit vld, input bit eol,
                       input bit wr, input bit rel);
    DATA_SOP = sop; DATA_VLD = vld; DATA_EOL = eol; WREADY = wr; BANK_RELEASE = rel;
    mon_en = 1'b1;
    model_step(sop, vld, eol, wr, rel);
  endtask

  task automatic run_cycles(input int n, input int pv, input int pe,
                            input int pr, input int pw);
    for (int i = 0; i < n; i++) begin
      @(posedge SYS_CLK); #1;
      drive(1'b0, $urandom_range(0, 99) < pv, $urandom_range(0, 99) < pe,
            $urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr);
    end
  endtask

  task automatic run_frame(input int start, input int pic, input bit pad, input bit fc,
                           input int n, input int pv, input int pe, input int pr, input int pw);
    @(posedge SYS_CLK); #1;
    cfg_start = start; cfg_pic = pic; cfg_pad = pad; cfg_fc = fc;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_cycles(n, pv, pe, pr, pw);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " WADDR"},        32'(WADDR), 32'd0);
    check({tag, " WEN"},          32'(WEN), 32'd0);
    check({tag, " BANK_FULL"},    32'(BANK_FULL), 32'd0);
    check({tag, " BANK_DONE"},    32'(BANK_DONE), 32'd0);
    check({tag, " BANK_DONE_ID"}, 32'(BANK_DONE_ID), 32'd0);
    check({tag, " FRAME_DONE"},   32'(FRAME_DONE), 32'd0);
  endtask

  task automatic mid_reset();
    @(posedge SYS_CLK); #1;
    mon_en = 1'b0;
    DATA_SOP = 1'b0; DATA_VLD = 1'b1; DATA_EOL = 1'b0; WREADY = 1'b1; BANK_RELEASE = 1'b0;
    SYS_RST = 1'b0;
    #1;
    check_zero_outputs("mid-reset");
    addr_q.delete(); done_q.delete(); frame_q.delete(); full_q.delete();
    model_reset();
    @(negedge SYS_CLK);
    DATA_VLD = 1'b0;
    @(negedge SYS_CLK);
    SYS_RST = 1'b1;
  endtask

  // Monitor: every sampled cycle pops the expected full flag; writes and pulses pop their queues.
  always @(negedge SYS_CLK) begin
    if (mon_en) begin
      if (full_q.size() == 0) unexpected("BANK_FULL", 32'(BANK_FULL));
      else check("BANK_FULL", 32'(BANK_FULL), 32'(full_q.pop_front()));
      if (WEN) begin
        if (addr_q.size() == 0) unexpected("WEN/WADDR", 32'(WADDR));
        else check("WADDR", 32'(WADDR), 32'(addr_q.pop_front()));
      end
      if (BANK_DONE) begin
        if (done_q.size() == 0) unexpected("BANK_DONE", 32'(BANK_DONE_ID));
        else check("BANK_DONE_ID", 32'(BANK_DONE_ID), 32'(done_q.pop_front()));
      end
      if (FRAME_DONE) begin
        if (frame_q.size() == 0) unexpected("FRAME_DONE", 32'(FRAME_DONE));
        else check("FRAME_DONE", 32'(FRAME_DONE), 32'(frame_q.pop_front()));
      end
    end
  end

  initial begin
    model_reset();
    #1 SYS_RST = 1'b0;
    #2 check_zero_outputs("reset");
    @(negedge SYS_CLK);
    SYS_RST = 1'b1;

    // Padded start, 4-line frame: 2 banks then frame end.
    run_frame(32'h010, 4, 1'b1, 1'b0, 40, 100, 20, 0, 100);
    // Unpadded, unlimited frame: fill all banks and stall, then release.
    run_frame(32'h010, 0, 1'b0, 1'b0, 80, 100, 25, 0, 100);
    run_cycles(80, 100, 25, 12, 100);
    // Odd frame length closes a half-filled bank.
    run_frame(0, 3, 1'b0, 1'b0, 60, 100, 20, 0, 100);
    run_cycles(10, 100, 20, 0, 100);
    // FC mode near the top of the address space, EOL noise ignored.
    run_frame(32'h3F0, 0, 1'b0, 1'b1, 1100, 100, 10, 0, 100);
    run_frame(32'h3F8, 0, 1'b0, 1'b1, 1200, 90, 10, 4, 90);
    // Abort mid-line.
    run_frame(32'h020, 5, 1'b1, 1'b0, 7, 100, 10, 0, 100);
    mid_reset();
    run_cycles(4, 100, 30, 0, 100);
    // Randomised frames.
    for (int f = 0; f < 30; f++) begin
      run_frame($urandom_range(0, SPAN - 1), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) == 0, $urandom_range(100, 300),
                $urandom_range(50, 100), $urandom_range(10, 40),
                $urandom_range(0, 20), $urandom_range(70, 100));
    end
    run_cycles(4, 0, 0, 0, 100);

    check("addr_q drained", 32'(addr_q.size()), 32'd0);
    check("done_q drained", 32'(done_q.size()), 32'd0);
    check("frame_q drained", 32'(frame_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
